riscv_regfile: RTL and testbench

RISCV_REGFILE -- requirements
Module: riscv_regfile

---
 rtl/riscv_regfile.sv | 87 ++++++++
 tb/tb_riscv_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 register file with per-register outstanding-writer counters (scoreboard locks).
// Define RISCV_REGFILE_BYPASS_EN to forward same-cycle writeback data and lock release to the outputs.
package riscv_pkg;
    parameter int REGISTER_PORTS = 2;
endpackage

module riscv_regfile #(
    parameter int REGISTER_PORTS = riscv_pkg::REGISTER_PORTS
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [REGISTER_PORTS-1:0]            register_lock_en,
    input  logic [REGISTER_PORTS-1:0][4:0]       register_lock,
    input  logic [REGISTER_PORTS-1:0]            register_write_en,
    input  logic [REGISTER_PORTS-1:0][4:0]       register_write,
    input  logic [REGISTER_PORTS-1:0][31:0]      register_write_data,
    output logic [31:0][31:0]                    register,
    output logic [31:0]                          register_locked,
    output logic                                 lock_error,
    output logic                                 write_error
);
    logic [31:0][31:0] data_q, data_d;
    logic [31:0][1:0]  pend_q, pend_d;
    logic signed [3:0] nxt;
    logic              lock_err_d, write_err_d;

    // Port order gives highest-numbered writer priority on data; counts net lock minus write.
    always_comb begin
        data_d      = data_q;
        pend_d      = pend_q;
        nxt         = '0;
        lock_err_d  = lock_error;
        write_err_d = write_error;
        for (int r = 1; r < 32; r++) begin
            nxt = $signed({2'b00, pend_q[r]});
            for (int p = 0; p < REGISTER_PORTS; p++) begin
                if (register_lock_en[p] && register_lock[p] == 5'(r))
                    nxt = nxt + 4'sd1;
                if (register_write_en[p] && register_write[p] == 5'(r)) begin
                    nxt       = nxt - 4'sd1;
                    data_d[r] = register_write_data[p];
                end
            end
            pend_d[r]   = nxt > 4'sd3 ? 2'd3 : nxt < 4'sd0 ? 2'd0 : nxt[1:0];
            lock_err_d  = lock_err_d | (nxt > 4'sd3);
            write_err_d = write_err_d | (nxt < 4'sd0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q      <= '0;
            pend_q      <= '0;
            lock_error  <= 1'b0;
            write_error <= 1'b0;
        end else begin
            data_q      <= data_d;
            pend_q      <= pend_d;
            lock_error  <= lock_err_d;
            write_error <= write_err_d;
        end
    end

`ifdef RISCV_REGFILE_BYPASS_EN
    logic [31:0][3:0] w_cnt;

    // Only writebacks are forwarded; new locks become visible a cycle later.
    always_comb begin
        register        = data_d;
        register_locked = '0;
        w_cnt           = '0;
        for (int r = 1; r < 32; r++) begin
            for (int p = 0; p < REGISTER_PORTS; p++)
                if (register_write_en[p] && register_write[p] == 5'(r))
                    w_cnt[r] = w_cnt[r] + 4'd1;
            register_locked[r] = ($signed({2'b00, pend_q[r]}) - $signed(w_cnt[r])) > 4'sd0;
        end
    end
`else
    always_comb begin
        register        = data_q;
        register_locked = '0;
        for (int r = 1; r < 32; r++)
            register_locked[r] = pend_q[r] != 2'd0;
    end
`endif
endmodule

// File: tb/tb_riscv_regfile.sv
// tb_riscv_regfile: scoreboard bench; driver pushes model expectations, monitor pops after each clock edge.
module tb_riscv_regfile;
    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        lock_en = '0;
    logic [1:0][4:0]   lock = '0;
    logic [1:0]        write_en = '0;
    logic [1:0][4:0]   write = '0;
    logic [1:0][31:0]  write_data = '0;
    logic [31:0][31:0] regs;
    logic [31:0]       locked;
    logic              lock_error, write_error;

    typedef struct packed {
        logic [31:0][31:0] regs;
        logic [31:0]       locked;
        logic              lerr;
        logic              werr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] m_data[32];
    int          m_pend[32];
    logic        m_lerr, m_werr;

    riscv_regfile dut (
        .clock(clock), .reset(reset),
        .register_lock_en(lock_en), .register_lock(lock),
        .register_write_en(write_en), .register_write(write),
        .register_write_data(write_data),
        .register(regs), .register_locked(locked),
        .lock_error(lock_error), .write_error(write_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_regs(input string name, input logic [31:0][31:0] act, input logic [31:0][31:0] exp);
        int bad;
        bad = -1;
        for (int r = 31; r >= 0; r--)
            if (act[r] !== exp[r]) bad = r;
        checks++;
        if (bad < 0) passed++;
        else $display("FAIL %s: x%0d got %h expected %h", name, bad, act[bad], exp[bad]);
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int r = 0; r < 32; r++) begin
            e.regs[r]   = m_data[r];
            e.locked[r] = m_pend[r] != 0;
        end
        e.lerr = m_lerr;
        e.werr = m_werr;
        return e;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            m_data[r] = '0;
            m_pend[r] = 0;
        end
        m_lerr = 1'b0;
        m_werr = 1'b0;
    endfunction

    // Reference: count locks/writes per register, apply net change, clamp and flag.
    function automatic void model_step();
        int l, w, n;
        for (int r = 1; r < 32; r++) begin
            l = 0;
            w = 0;
            for (int p = 0; p < 2; p++) begin
                if (lock_en[p] && lock[p] == r) l++;
                if (write_en[p] && write[p] == r) begin
                    w++;
                    m_data[r] = write_data[p];
                end
            end
            n = m_pend[r] + l - w;
            if (n > 3) begin n = 3; m_lerr = 1'b1; end
            if (n < 0) begin n = 0; m_werr = 1'b1; end
            m_pend[r] = n;
        end
    endfunction

    task automatic drive(input logic [1:0] le, input logic [4:0] l0, input logic [4:0] l1,
                         input logic [1:0] we, input logic [4:0] w0, input logic [4:0] w1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clock);
        lock_en    = le;
        lock[0]    = l0;
        lock[1]    = l1;
        write_en   = we;
        write[0]   = w0;
        write[1]   = w1;
        write_data[0] = d0;
        write_data[1] = d1;
        model_step();
        q.push_back(snapshot());
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left expected 0", q.size());
    endtask

    // Async reset with junk on the inputs; nothing presented during reset may stick.
    task automatic do_reset();
        drain();
        reset      = 1'b0;
        lock_en    = 2'b11;
        lock       = {5'd6, 5'd12};
        write_en   = 2'b11;
        write      = {5'd6, 5'd13};
        write_data = {32'hA5A5A5A5, 32'h5A5A5A5A};
        #1;
        chk_regs("reset_regs", regs, '0);
        chk("reset_locked", locked, '0);
        chk("reset_errs", {30'd0, lock_error, write_error}, '0);
        model_clear();
        @(negedge clock);
        chk_regs("reset_hold_regs", regs, '0);
        chk("reset_hold_locked", locked, '0);
        lock_en  = '0;
        write_en = '0;
        reset    = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk_regs("regs", regs, e.regs);
                chk("locked", locked, e.locked);
                chk("lock_error", {31'd0, lock_error}, {31'd0, e.lerr});
                chk("write_error", {31'd0, write_error}, {31'd0, e.werr});
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(negedge clock);
        do_reset();
        // lock then write x5
        drive(2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        drive(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF);
        idle();
        // double lock x7, two single writes
        drive(2'b11, 5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h78, 32'h0);
        // x0 is inert
        drive(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        // same-cycle lock and write on an idle register nets to zero
        drive(2'b01, 5'd11, 5'd0, 2'b10, 5'd0, 5'd11, 32'h0, 32'h1111);
        // saturate x3
        repeat (4) drive(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        repeat (3) drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'h3, 32'h0);
        idle();
        do_reset();
        // both ports write x9 with no lock: port 1 wins, write_error
        drive(2'b00, 5'd0, 5'd0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h2);
        idle();
        do_reset();
        // locks dropped by reset make the later writeback an error
        drive(2'b01, 5'd12, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        do_reset();
        drive(2'b01, 5'd0, 5'd0, 2'b01, 5'd12, 5'd0, 32'hC0FFEE, 32'h0);
        do_reset();
        // random traffic concentrated on a few registers
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom);
            if (i == 150) do_reset();
        end
        drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
